// File: rtl/game_pkg.sv
// Shared constants for the number-guessing game controller: state codes,
// round defaults and status-bar pictures.
package game_pkg;

   localparam int unsigned ROUND_TIME_DEF = 9;
   localparam int unsigned NUM_ROUNDS_DEF = 3;
   localparam int unsigned STATE_W        = 3;
   localparam int unsigned TIME_W         = 4;
   localparam int unsigned NUM_W          = 7;
   localparam int unsigned LED_W          = 16;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_GREET  = 3'd1;
   localparam logic [2:0] ST_ROUND1 = 3'd2;
   localparam logic [2:0] ST_ROUND2 = 3'd3;
   localparam logic [2:0] ST_ROUND3 = 3'd4;
   localparam logic [2:0] ST_WIN    = 3'd5;
   localparam logic [2:0] ST_LOSE   = 3'd6;

   localparam logic [LED_W-1:0] LED_OFF   = 16'h0000;
   localparam logic [LED_W-1:0] LED_GREET = 16'h8001;
   localparam logic [LED_W-1:0] LED_WIN   = 16'hFFFF;

   // Thermometer bar: the low t bits set.
   function automatic logic [LED_W-1:0] led_thermo(input logic [TIME_W-1:0] t);
      return LED_W'((32'd1 << t) - 32'd1);
   endfunction

endpackage

// File: rtl/round_timer.sv
// Per-round countdown: load to the round time, decrement on tick, clear to 0.
// Also exposes its next value so the owner can register derived outputs.
module round_timer
   import game_pkg::*;
#(
   parameter int unsigned LOAD_VAL = ROUND_TIME_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load_i,
   input  logic              tick_i,
   input  logic              clear_i,
   output logic [TIME_W-1:0] time_left_o,
   output logic [TIME_W-1:0] time_left_nxt_c,
   output logic              expired_c
);

   logic [TIME_W-1:0] time_left_q, time_left_d;

   always_comb begin
      time_left_d = time_left_q;
      if (clear_i)
         time_left_d = '0;
      else if (load_i)
         time_left_d = TIME_W'(LOAD_VAL);
      else if (tick_i && (time_left_q != '0))
         time_left_d = time_left_q - TIME_W'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) time_left_q <= '0;
      else     time_left_q <= time_left_d;
   end

   assign time_left_o     = time_left_q;
   assign time_left_nxt_c = time_left_d;
   assign expired_c       = (time_left_q == '0);

endmodule

// File: rtl/game_ctrl.sv
// Three-round number-guessing game controller: greets, runs timed rounds,
// and reports win/lose with registered display and beep outputs.
module game_ctrl
   import game_pkg::*;
#(
   parameter int unsigned ROUND_TIME = ROUND_TIME_DEF,
   parameter int unsigned NUM_ROUNDS = NUM_ROUNDS_DEF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               sure,
   input  logic [NUM_W-1:0]   sw,
   input  logic [NUM_W-1:0]   rand_num,
   input  logic               tick_1hz,
   output logic [STATE_W-1:0] state,
   output logic [1:0]         round,
   output logic [NUM_W-1:0]   target,
   output logic [TIME_W-1:0]  time_left,
   output logic [LED_W-1:0]   led,
   output logic               rand_req,
   output logic               beep_ok,
   output logic               beep_fail
);

   localparam logic [2:0] ST_LAST = 3'(32'(ST_ROUND1) + NUM_ROUNDS - 32'd1);

   logic [STATE_W-1:0] state_q, state_d;
   logic [1:0]         round_q, round_d;
   logic [NUM_W-1:0]   target_q, target_d;
   logic [LED_W-1:0]   led_q, led_d;
   logic               rand_req_q, rand_req_d;
   logic               beep_ok_q, beep_ok_d;
   logic               beep_fail_q, beep_fail_d;

   logic               tmr_load, tmr_tick, tmr_clear, tmr_expired;
   logic [TIME_W-1:0]  tmr_nxt;

   round_timer #(.LOAD_VAL(ROUND_TIME)) u_timer (
      .clk             (clk),
      .rst             (rst),
      .load_i          (tmr_load),
      .tick_i          (tmr_tick),
      .clear_i         (tmr_clear),
      .time_left_o     (time_left),
      .time_left_nxt_c (tmr_nxt),
      .expired_c       (tmr_expired)
   );

   // Next-state and pulse decode; start low dominates, then sure, then tick.
   always_comb begin
      state_d     = state_q;
      target_d    = target_q;
      tmr_load    = 1'b0;
      tmr_tick    = 1'b0;
      tmr_clear   = 1'b0;
      rand_req_d  = 1'b0;
      beep_ok_d   = 1'b0;
      beep_fail_d = 1'b0;
      if (!start) begin
         state_d   = ST_IDLE;
         target_d  = '0;
         tmr_clear = 1'b1;
      end else begin
         case (state_q)
            ST_IDLE: state_d = ST_GREET;
            ST_GREET: begin
               if (sure) begin
                  state_d    = ST_ROUND1;
                  target_d   = rand_num;
                  tmr_load   = 1'b1;
                  rand_req_d = 1'b1;
               end
            end
            ST_ROUND1, ST_ROUND2, ST_ROUND3: begin
               if (sure) begin
                  if (sw == target_q) begin
                     beep_ok_d = 1'b1;
                     if (state_q == ST_LAST) begin
                        state_d = ST_WIN;
                     end else begin
                        state_d    = state_q + 3'd1;
                        target_d   = rand_num;
                        tmr_load   = 1'b1;
                        rand_req_d = 1'b1;
                     end
                  end else begin
                     state_d     = ST_LOSE;
                     beep_fail_d = 1'b1;
                  end
               end else if (tick_1hz) begin
                  if (tmr_expired) begin
                     state_d     = ST_LOSE;
                     beep_fail_d = 1'b1;
                  end else begin
                     tmr_tick = 1'b1;
                  end
               end
            end
            ST_WIN, ST_LOSE: begin
               if (sure) begin
                  state_d   = ST_GREET;
                  target_d  = '0;
                  tmr_clear = 1'b1;
               end
            end
            default: begin
               state_d   = ST_IDLE;
               target_d  = '0;
               tmr_clear = 1'b1;
            end
         endcase
      end
   end

   // Display outputs follow the next state so they line up with it.
   always_comb begin
      round_d = 2'd0;
      led_d   = LED_OFF;
      case (state_d)
         ST_GREET: led_d = LED_GREET;
         ST_WIN:   led_d = LED_WIN;
         ST_ROUND1, ST_ROUND2, ST_ROUND3: begin
            round_d = 2'(state_d - 3'd1);
            led_d   = led_thermo(tmr_nxt);
         end
         default: led_d = LED_OFF;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         round_q     <= 2'd0;
         target_q    <= '0;
         led_q       <= LED_OFF;
         rand_req_q  <= 1'b0;
         beep_ok_q   <= 1'b0;
         beep_fail_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         round_q     <= round_d;
         target_q    <= target_d;
         led_q       <= led_d;
         rand_req_q  <= rand_req_d;
         beep_ok_q   <= beep_ok_d;
         beep_fail_q <= beep_fail_d;
      end
   end

   assign state     = state_q;
   assign round     = round_q;
   assign target    = target_q;
   assign led       = led_q;
   assign rand_req  = rand_req_q;
   assign beep_ok   = beep_ok_q;
   assign beep_fail = beep_fail_q;

endmodule

// File: tb/tb_game_ctrl.sv
// Bench for game_ctrl: directed scenarios followed by random play, every
// cycle compared against a rule-level model of the game.
module tb_game_ctrl;

   logic        clk = 1'b0;
   logic        rst, start, sure, tick_1hz;
   logic [6:0]  sw, rand_num;
   logic [2:0]  state;
   logic [1:0]  round;
   logic [6:0]  target;
   logic [3:0]  time_left;
   logic [15:0] led;
   logic        rand_req, beep_ok, beep_fail;

   int checks = 0;
   int errors = 0;

   // Reference model of the game, kept as plain integers.
   int m_state, m_target, m_time;
   int m_rreq, m_ok, m_fail;

   game_ctrl dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .sure      (sure),
      .sw        (sw),
      .rand_num  (rand_num),
      .tick_1hz  (tick_1hz),
      .state     (state),
      .round     (round),
      .target    (target),
      .time_left (time_left),
      .led       (led),
      .rand_req  (rand_req),
      .beep_ok   (beep_ok),
      .beep_fail (beep_fail)
   );

   always #5 clk = ~clk;

   task automatic model_update();
      m_rreq = 0; m_ok = 0; m_fail = 0;
      if (rst) begin
         m_state = 0; m_target = 0; m_time = 0;
      end else if (!start) begin
         m_state = 0; m_target = 0; m_time = 0;
      end else if (m_state == 0) begin
         m_state = 1;
      end else if (m_state == 1) begin
         if (sure) begin
            m_state = 2; m_target = int'(rand_num); m_time = 9; m_rreq = 1;
         end
      end else if (m_state >= 2 && m_state <= 4) begin
         if (sure) begin
            if (int'(sw) == m_target) begin
               m_ok = 1;
               if (m_state == 4) m_state = 5;
               else begin
                  m_state = m_state + 1; m_target = int'(rand_num);
                  m_time = 9; m_rreq = 1;
               end
            end else begin
               m_state = 6; m_fail = 1;
            end
         end else if (tick_1hz) begin
            if (m_time == 0) begin
               m_state = 6; m_fail = 1;
            end else m_time = m_time - 1;
         end
      end else if (sure) begin
         m_state = 1; m_target = 0; m_time = 0;
      end
   endtask

   function automatic int exp_led();
      if (m_state == 1) return 'h8001;
      if (m_state == 5) return 'hFFFF;
      if (m_state >= 2 && m_state <= 4) return (1 << m_time) - 1;
      return 0;
   endfunction

   task automatic check(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s at t=%0t: observed=%0h expected=%0h", tag, $time, obs, exp);
      end
   endtask

   task automatic check_all();
      check("state",     int'(state),     m_state);
      check("round",     int'(round),     (m_state >= 2 && m_state <= 4) ? m_state - 1 : 0);
      check("target",    int'(target),    m_target);
      check("time_left", int'(time_left), m_time);
      check("led",       int'(led),       exp_led());
      check("rand_req",  int'(rand_req),  m_rreq);
      check("beep_ok",   int'(beep_ok),   m_ok);
      check("beep_fail", int'(beep_fail), m_fail);
   endtask

   // One clock: drive inputs after the previous check, update model at the edge, sample 1 time unit later.
   task automatic step(input logic r, input logic s, input logic su,
                       input logic [6:0] swv, input logic [6:0] rn, input logic tk);
      rst = r; start = s; sure = su; sw = swv; rand_num = rn; tick_1hz = tk;
      @(posedge clk);
      model_update();
      #1;
      check_all();
   endtask

   task automatic play(input logic su, input logic [6:0] swv, input logic tk);
      step(1'b0, 1'b1, su, swv, 7'($urandom_range(0, 127)), tk);
   endtask

   task automatic answer_ok(input logic [6:0] rn, input logic tk);
      step(1'b0, 1'b1, 1'b1, 7'(m_target), rn, tk);
   endtask

   initial begin
      m_state = 0; m_target = 0; m_time = 0;
      m_rreq = 0; m_ok = 0; m_fail = 0;
      rst = 1'b1; start = 1'b0; sure = 1'b0; sw = '0; rand_num = '0; tick_1hz = 1'b0;

      step(1'b1, 1'b0, 1'b0, 7'd0, 7'd0, 1'b0);
      step(1'b1, 1'b1, 1'b1, 7'd0, 7'd5, 1'b1);

      // Greeting, then first round with target 42
      play(1'b0, 7'd0, 1'b1);
      play(1'b0, 7'd0, 1'b1);
      step(1'b0, 1'b1, 1'b1, 7'd0, 7'd42, 1'b0);
      play(1'b0, 7'd0, 1'b0);

      // Three correct answers, including target 0 and 127
      answer_ok(7'd0, 1'b0);
      answer_ok(7'd127, 1'b0);
      answer_ok(7'd9, 1'b0);
      play(1'b0, 7'd0, 1'b1);

      // Wrong answer in round 2
      play(1'b1, 7'd0, 1'b0);
      step(1'b0, 1'b1, 1'b1, 7'd0, 7'd100, 1'b0);
      answer_ok(7'd64, 1'b0);
      play(1'b1, 7'(m_target + 1), 1'b0);
      play(1'b0, 7'd0, 1'b1);

      // Timeout in round 1
      play(1'b1, 7'd0, 1'b0);
      play(1'b1, 7'd0, 1'b0);
      for (int i = 0; i < 10; i++) begin
         play(1'b0, 7'd0, 1'b1);
         play(1'b0, 7'd0, 1'b0);
      end

      // Correct answer coincident with a tick at time_left 5
      play(1'b1, 7'd0, 1'b0);
      play(1'b1, 7'd0, 1'b0);
      for (int i = 0; i < 4; i++) play(1'b0, 7'd0, 1'b1);
      answer_ok(7'd77, 1'b1);

      // Start drop mid round 3
      answer_ok(7'd33, 1'b0);
      play(1'b0, 7'd0, 1'b1);
      step(1'b0, 1'b0, 1'b1, 7'(m_target), 7'd1, 1'b1);
      play(1'b0, 7'd0, 1'b0);

      // Reset mid round 3
      play(1'b1, 7'd0, 1'b0);
      answer_ok(7'd12, 1'b0);
      answer_ok(7'd13, 1'b0);
      step(1'b1, 1'b1, 1'b1, 7'(m_target), 7'd3, 1'b1);
      play(1'b0, 7'd0, 1'b0);

      // Random play
      for (int i = 0; i < 600; i++) begin
         logic r, s, su, tk;
         logic [6:0] swv;
         r   = ($urandom_range(0, 99) == 0);
         s   = ($urandom_range(0, 59) != 0);
         su  = ($urandom_range(0, 4) == 0);
         tk  = ($urandom_range(0, 2) == 0);
         swv = ($urandom_range(0, 3) != 0) ? 7'(m_target) : 7'($urandom_range(0, 127));
         step(r, s, su, swv, 7'($urandom_range(0, 127)), tk);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
